maj_fold_seq: RTL
=================

Name: maj_fold_seq

Overview:
Sequential, folded threshold (majority) evaluator for wide input vectors. It is the hardware consumer of the N-bit vectors our majority testbenches generate.
- Accepts one N-bit vector per transaction over a valid/ready handshake.
- Counts its ones CHUNK bits per cycle.
- Returns the majority decision plus the final count over a second valid/ready handshake.
- Serves as the area-lean folded counterpart to the flat combinational majority tops. It is also the on-chip reference for checking them.

Parameters:
N, 49, input vector width (≥1)
CHUNK, 7, bits counted per cycle (1..N)
THRESH, (N+1)/2, decision threshold; y=1 iff count ≥ THRESH
EARLY_EXIT, 0, 1 = finish as soon as the decision is fixed
(derived) NCH = ceil(N/CHUNK); CW = clog2(N+1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_x  in  N  vector to evaluate
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y  out  1  majority decision
count  out  CW  ones counted (partial if early exit)

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset, asynchronous, may arrive in any state:
  - state=IDLE, shift reg=0, acc=0, idx=0, y=0, count=0, out_valid=0.
  - Any in-flight transaction is dropped; no result is emitted.
  - in_ready=1 from the first clk edge after rst_n deasserts. in_x is ignored while rst_n=0.
- FSM states: IDLE, ACCUM, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE); it is registered.
- IDLE: on in_valid&&in_ready → latch in_x into the shift reg (zero-padded to NCH*CHUNK bits), acc=0, idx=0 → ACCUM.
- ACCUM, each cycle:
  - acc_n = acc + popcount(shreg[CHUNK-1:0]); shreg >>= CHUNK; idx++.
  - Go to DONE if idx==NCH-1.
  - If EARLY_EXIT=1, also go to DONE if acc_n ≥ THRESH, or if acc_n + rem < THRESH, where rem = max(0, N-(idx+1)*CHUNK).
  - On entering DONE: y = (acc_n ≥ THRESH), count = acc_n.
- Latency: out_valid rises NCH clock edges after the accept edge (7 for defaults). With early exit it can rise earlier, but never fewer than 1 edge.
- DONE: y, count and out_valid are held stable until out_ready=1. On out_valid&&out_ready → IDLE; in_ready rises the next cycle.
- No bypass: there is no accept in the same cycle as result handoff. Throughput is 1 vector per NCH+2 cycles without stalls.
- in_x changes while not accepting have no effect. in_valid dropping without an accept is legal.
- Width rules:
  - acc is CW bits and never overflows (max N).
  - The chunk popcount is clog2(CHUNK+1) bits, zero-extended into the add.
  - THRESH > N: y is always 0. THRESH == 0: y is always 1, and with early exit the block finishes after the first chunk.

Decomposition:
- maj_fold_pkg: state enum (IDLE/ACCUM/DONE) and a clog2 function.
- Derived constants NCH, CW and PCW are computed in the module from parameters.
- One sub-module: chunk_popcount. It is a purely combinational CHUNK-bit ones counter, parameterized by width, and is instantiated once.

Test Plan:
- Defaults, in_x=0, out_ready=1 → in_ready falls after accept; out_valid rises 7 edges after accept; y=0, count=0.
- in_x=all ones (49'h1_FFFF_FFFF_FFFF) → y=1, count=49, after 7 cycles.
- Boundary: in_x=25 low ones (49'h1FF_FFFF) → y=1, count=25. Then 24 ones (49'hFF_FFFF) → y=0, count=24. Two back-to-back transactions; the second is accepted the cycle after the first handoff.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, y and count stay constant and in_ready stays 0. Release → one handoff, then in_ready=1.
- EARLY_EXIT=1, all ones → DONE after 4 edges (acc=28≥25): y=1, count=28. in_x=0 → DONE after 4 edges (0+21<25): y=0, count=0.
- Reset: assert rst_n=0 mid-ACCUM (idx=3) → out_valid=0, count=0, y=0 immediately. After release, in_ready=1, no stale result appears, and a fresh all-ones vector gives count=49.

Source files
------------

// File: rtl/maj_fold_pkg.sv
// Shared types and constant helpers for the folded majority evaluator.
package maj_fold_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Ceiling log2; returns the bit width needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Purely combinational ones counter over a W-bit slice.
module chunk_popcount
    import maj_fold_pkg::*;
#(
    parameter int W  = 7,
    parameter int PW = clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [PW-1:0] ones
);

    always_comb begin
        // NOTE: 'ones' gets a value before the loop on every evaluation, so no latch is inferred.
        ones = '0;
        for (int i = 0; i < W; i++) begin
            ones = ones + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/maj_fold_seq.sv
// Folded threshold evaluator: counts CHUNK bits of the latched vector per cycle,
// then presents the decision and count over a valid/ready handshake.
module maj_fold_seq
    import maj_fold_pkg::*;
#(
    parameter int N          = 49,
    parameter int CHUNK      = 7,
    parameter int THRESH     = (N + 1) / 2,
    parameter int EARLY_EXIT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    y,
    output logic [clog2(N+1)-1:0]   count
);

    localparam int NCH = (N + CHUNK - 1) / CHUNK;
    localparam int CW  = clog2(N + 1);
    localparam int PCW = clog2(CHUNK + 1);
    localparam int SW  = NCH * CHUNK;
    localparam int IW  = clog2(NCH + 1);

    localparam int unsigned N_U     = N;
    localparam int unsigned CHUNK_U = CHUNK;
    localparam int unsigned THR_U   = THRESH;

    state_t         state, state_nxt;
    logic [SW-1:0]  shreg, shreg_nxt;
    logic [CW-1:0]  acc, acc_nxt;
    logic [IW-1:0]  idx, idx_nxt;
    logic           y_nxt;
    logic [CW-1:0]  count_nxt;

    logic [PCW-1:0] chunk_ones;
    logic [CW-1:0]  sum;
    logic [31:0]    consumed;
    logic [31:0]    rem;
    logic           sum_ge;
    logic           last_chunk;
    logic           decided;
    logic           finish;

    chunk_popcount #(
        .W  (CHUNK),
        .PW (PCW)
    ) u_chunk_popcount (
        .bits (shreg[CHUNK-1:0]),
        .ones (chunk_ones)
    );

    // Bits still unseen after this chunk; clamped because the last chunk may be padding.
    assign sum        = acc + CW'(chunk_ones);
    assign consumed   = (32'(idx) + 32'd1) * CHUNK_U;
    assign rem        = (consumed >= N_U) ? 32'd0 : (N_U - consumed);
    assign sum_ge     = (32'(sum) >= THR_U);
    assign last_chunk = (idx == IW'(NCH - 1));
    assign decided    = sum_ge || ((32'(sum) + rem) < THR_U);
    assign finish     = last_chunk || ((EARLY_EXIT != 0) && decided);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        // NOTE: blocking assignments in combinational logic; defaults first keep every path assigned.
        state_nxt = state;
        shreg_nxt = shreg;
        acc_nxt   = acc;
        idx_nxt   = idx;
        y_nxt     = y;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shreg_nxt = SW'(in_x);
                    acc_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                acc_nxt   = sum;
                shreg_nxt = shreg >> CHUNK;
                idx_nxt   = idx + IW'(1);
                if (finish) begin
                    y_nxt     = sum_ge;
                    count_nxt = sum;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            acc   <= '0;
            idx   <= '0;
            y     <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            acc   <= acc_nxt;
            idx   <= idx_nxt;
            y     <= y_nxt;
            count <= count_nxt;
        end
    end

endmodule
